// File: rtl/keypad_bcd_encoder.sv
// Decimal keypad to BCD encoder: debounces ten key lines, rejects multi-key presses
// and shifts each clean digit into a NUM_DIGITS-wide BCD display register.
// Optional macro KEYPAD_BCD_SYNC_EN adds a synchronizer stage ahead of key_s.
module keypad_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_DIGITS      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              key,
    output logic [3:0]              bcd_digit,
    output logic                    digit_valid,
    output logic                    err_multi,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [9:0]              cand;
    logic [9:0]              key_s;
    logic [CNT_W-1:0]        press_cnt_next;
    logic                    press_accept;
    logic [CNT_W-1:0]        release_cnt_next;
    logic                    release_done;
    logic                    one_hot;
    logic [3:0]              key_index;
    logic [4*NUM_DIGITS-1:0] digits_shifted;

`ifdef KEYPAD_BCD_SYNC_EN
    // The first flop absorbs metastability; key_s is the second synchronizer stage.
    logic [9:0] key_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= '0;
            key_s    <= '0;
        end else begin
            key_meta <= key;
            key_s    <= key_meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s <= '0;
        end else begin
            key_s <= key;
        end
    end
`endif

    always_comb begin
        one_hot   = (key_s != 10'd0) && ((key_s & (key_s - 10'd1)) == 10'd0);
        key_index = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_s[i]) begin
                key_index = 4'(i);
            end
        end
    end

    // A fresh or changed sample restarts the run at 1, so DEBOUNCE_CYCLES = 1 accepts at once.
    always_comb begin
        press_cnt_next = cnt;
        if (state == IDLE || key_s != cand) begin
            press_cnt_next = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            press_cnt_next = cnt + CNT_ONE;
        end
        press_accept = (key_s != 10'd0) && (press_cnt_next == CNT_MAX);
    end

    always_comb begin
        release_cnt_next = cnt;
        if (key_s != 10'd0) begin
            release_cnt_next = '0;
        end else if (cnt != CNT_MAX) begin
            release_cnt_next = cnt + CNT_ONE;
        end
        release_done = (key_s == 10'd0) && (release_cnt_next == CNT_MAX);
    end

    generate
        if (NUM_DIGITS == 1) begin : g_single
            always_comb digits_shifted = key_index;
        end else begin : g_multi
            always_comb digits_shifted = {digits[4*NUM_DIGITS-5:0], key_index};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            bcd_digit   <= '0;
            digit_valid <= 1'b0;
            err_multi   <= 1'b0;
            digits      <= '0;
            busy        <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            err_multi   <= 1'b0;
            case (state)
                IDLE, DEBOUNCE: begin
                    if (key_s == 10'd0) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cand <= key_s;
                        cnt  <= press_cnt_next;
                        busy <= 1'b1;
                        if (press_accept) begin
                            state <= PRESSED;
                            if (one_hot) begin
                                bcd_digit   <= key_index;
                                digit_valid <= 1'b1;
                                digits      <= digits_shifted;
                            end else begin
                                err_multi <= 1'b1;
                            end
                        end else begin
                            state <= DEBOUNCE;
                        end
                    end
                end
                PRESSED: begin
                    state <= RELEASE;
                    cnt   <= '0;
                end
                RELEASE: begin
                    if (release_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= release_cnt_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Scoreboard bench for keypad_bcd_encoder: a sliding-window reference model predicts
// each pulse and a negedge monitor compares it against the DUT.
module tb_keypad_bcd_encoder;

    localparam int D = 4;
    localparam int N = 2;
`ifdef KEYPAD_BCD_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam longint DIG_MOD = longint'(1) << (4 * N);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [9:0]     key = '0;
    logic [3:0]     bcd_digit;
    logic           digit_valid;
    logic           err_multi;
    logic [4*N-1:0] digits;
    logic           busy;

    keypad_bcd_encoder #(.DEBOUNCE_CYCLES(D), .NUM_DIGITS(N)) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .bcd_digit(bcd_digit),
        .digit_valid(digit_valid),
        .err_multi(err_multi),
        .digits(digits),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_err;
        int       edge_no;
        int       bcd;
        longint   digs;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] pipe[$];
    logic [9:0] hist[$];
    logic [9:0] rel[$];
    logic [9:0] model_s;
    exp_t       mon_e;
    int         phase = 0;
    int         m_bcd = 0;
    longint     m_digs = 0;
    bit         m_busy = 0;
    int         cycle = 0;
    int         tests = 0;
    int         fails = 0;
    int         valid_count = 0;
    int         err_count = 0;
    int         first_valid_edge = -1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] k, input int n);
        key = k;
        repeat (n) @(negedge clk);
    endtask

    // A press is accepted once the last D samples since arming are one identical nonzero value.
    task automatic model_accept(input logic [9:0] s);
        exp_t e;
        int   idx;
        idx = 0;
        for (int i = 0; i < 10; i++) if (s[i]) idx = i;
        if ($countones(s) == 1) begin
            m_bcd  = idx;
            m_digs = (m_digs * 16 + idx) % DIG_MOD;
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.edge_no = cycle;
        e.bcd     = m_bcd;
        e.digs    = m_digs;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic [9:0] s);
        bit same;
        case (phase)
            0: begin
                if (s == 10'd0) begin
                    hist.delete();
                    m_busy = 1'b0;
                end else begin
                    hist.push_back(s);
                    if (hist.size() > D) hist.delete(0);
                    m_busy = 1'b1;
                    same = (hist.size() == D);
                    foreach (hist[i]) if (hist[i] != s) same = 1'b0;
                    if (same) begin
                        model_accept(s);
                        phase = 1;
                    end
                end
            end
            1: begin
                phase = 2;
                rel.delete();
                m_busy = 1'b1;
            end
            default: begin
                rel.push_back(s);
                if (rel.size() > D) rel.delete(0);
                same = (rel.size() == D);
                foreach (rel[i]) if (rel[i] != 10'd0) same = 1'b0;
                if (same) begin
                    phase = 0;
                    hist.delete();
                    m_busy = 1'b0;
                end else begin
                    m_busy = 1'b1;
                end
            end
        endcase
    endtask

    // The model sees each driven key value LAT edges later, as the DUT's key_s does.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle = 0;
            pipe.delete();
            for (int i = 0; i < LAT; i++) pipe.push_back(10'd0);
            hist.delete();
            rel.delete();
            exp_q.delete();
            phase  = 0;
            m_busy = 1'b0;
            m_bcd  = 0;
            m_digs = 0;
        end else begin
            cycle++;
            pipe.push_back(key);
            model_s = pipe.pop_front();
            model_step(model_s);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].edge_no < cycle) begin
                tests++;
                fails++;
                $display("[TB] FAIL missed_pulse: got none, expected pulse at edge %0d (cycle %0d)",
                         exp_q[0].edge_no, cycle);
                exp_q.delete(0);
            end
            checkOutput("pulse_exclusive", longint'(digit_valid && err_multi), 0);
            if (digit_valid || err_multi) begin
                if (digit_valid) valid_count++;
                if (err_multi) err_count++;
                if (digit_valid && first_valid_edge < 0) first_valid_edge = cycle;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b, expected no pulse (cycle %0d)",
                             digit_valid, err_multi, cycle);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("pulse_kind_err", longint'(err_multi), longint'(mon_e.is_err));
                    checkOutput("pulse_edge", cycle, mon_e.edge_no);
                    checkOutput("pulse_bcd", bcd_digit, mon_e.bcd);
                    checkOutput("pulse_digits", digits, mon_e.digs);
                end
            end
            checkOutput("busy", busy, longint'(m_busy));
            checkOutput("bcd_digit", bcd_digit, m_bcd);
            checkOutput("digits", digits, m_digs);
        end
    end

    task automatic asyncReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_bcd_digit", bcd_digit, 0);
        checkOutput("rst_digit_valid", longint'(digit_valid), 0);
        checkOutput("rst_err_multi", longint'(err_multi), 0);
        checkOutput("rst_digits", digits, 0);
        checkOutput("rst_busy", longint'(busy), 0);
        key = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int v0;
        int e0;
        logic [9:0] k;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_bcd_digit", bcd_digit, 0);
        checkOutput("reset_digit_valid", longint'(digit_valid), 0);
        checkOutput("reset_err_multi", longint'(err_multi), 0);
        checkOutput("reset_digits", digits, 0);
        checkOutput("reset_busy", longint'(busy), 0);
        rst = 1'b0;

        applyStimulus(10'b0010000000, 12);
        checkOutput("first_valid_edge", first_valid_edge, D + LAT);
        checkOutput("hold_one_pulse", valid_count, 1);
        checkOutput("hold_bcd_7", bcd_digit, 7);
        checkOutput("hold_digits_07", digits, 'h07);
        applyStimulus(10'd0, 8);

        applyStimulus(10'd1 << 3, 8);
        applyStimulus(10'd0, 8);
        applyStimulus(10'd1 << 9, 8);
        applyStimulus(10'd0, 8);
        checkOutput("digits_39", digits, 'h39);
        applyStimulus(10'd1 << 5, 8);
        applyStimulus(10'd0, 8);
        checkOutput("digits_95", digits, 'h95);

        v0 = valid_count;
        e0 = err_count;
        applyStimulus(10'b0000100001, 10);
        applyStimulus(10'd0, 8);
        checkOutput("multi_err_pulse", err_count, e0 + 1);
        checkOutput("multi_no_valid", valid_count, v0);
        checkOutput("multi_digits_kept", digits, 'h95);

        v0 = valid_count;
        applyStimulus(10'd1 << 2, 2);
        applyStimulus(10'd0, 1);
        applyStimulus(10'd1 << 2, 2);
        applyStimulus(10'd0, 6);
        checkOutput("bounce_no_pulse", valid_count, v0);
        checkOutput("bounce_idle", longint'(busy), 0);
        applyStimulus(10'd1 << 2, 8);
        applyStimulus(10'd0, 8);
        checkOutput("bounce_then_press", valid_count, v0 + 1);
        checkOutput("bounce_bcd_2", bcd_digit, 2);

        v0 = valid_count;
        applyStimulus(10'd1 << 4, 8);
        repeat (3) begin
            applyStimulus(10'd0, 2);
            applyStimulus(10'd1 << 4, 2);
        end
        applyStimulus(10'd1 << 4, 5);
        checkOutput("release_bounce_busy", longint'(busy), 1);
        checkOutput("release_bounce_one_pulse", valid_count, v0 + 1);
        applyStimulus(10'd0, 8);
        checkOutput("release_done_idle", longint'(busy), 0);

        applyStimulus(10'd1 << 1, 8);
        applyStimulus(10'd0, 8);
        applyStimulus(10'd1 << 2, 8);
        applyStimulus(10'd0, 8);
        checkOutput("digits_12", digits, 'h12);
        applyStimulus(10'd1 << 6, 3);
        asyncReset();

        applyStimulus(10'd1 << 1, 8);
        applyStimulus(10'd0, 8);
        applyStimulus(10'd1 << 2, 10);
        checkOutput("digits_12_in_release", digits, 'h12);
        checkOutput("busy_in_release", longint'(busy), 1);
        asyncReset();
        applyStimulus(10'd1 << 6, 8);
        applyStimulus(10'd0, 8);
        checkOutput("digits_06", digits, 'h06);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1:    k = 10'($urandom) | (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
                2:       k = (10'd1 << $urandom_range(0, 4)) | (10'd1 << $urandom_range(5, 9));
                default: k = 10'd1 << $urandom_range(0, 9);
            endcase
            applyStimulus(k, $urandom_range(1, D + 3));
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(10'd0, $urandom_range(1, 2));
                applyStimulus(k, $urandom_range(1, D + 2));
            end
            applyStimulus(10'd0, $urandom_range(0, D + 3));
        end
        applyStimulus(10'd0, 2 * D + 6);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cycle);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/keypad_bcd_encoder.md
# keypad_bcd_encoder

- Converts a 10-line decimal keypad (one line per digit 0–9) into 4-bit BCD.
- Debounces the key lines, rejects simultaneous presses, and emits one BCD digit per clean press.
- Shifts accepted digits into a multi-digit BCD register that drives the seven-segment/LED display path.
- Inverse of the BCD-to-decimal decoder: digit-line input, BCD output.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive identical samples required to accept a press or a release; legal range ≥ 1.
- NUM_DIGITS, default 2: number of BCD digits held in the display register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key  in  10  key lines; key[i] high = decimal key i pressed.
- bcd_digit  out  4  BCD code of the last accepted key (0–9).
- digit_valid  out  1  one-cycle pulse when bcd_digit is updated.
- err_multi  out  1  one-cycle pulse when a stable press has more than one key line high.
- digits  out  4*NUM_DIGITS  BCD display register; digits[3:0] is the newest digit.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation

Input sampling:
- key is registered into key_s every cycle.
- The FSM operates only on key_s.

FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE:
  - key_s == 0: stay.
  - key_s != 0: cand ← key_s, cnt ← 1, go to DEBOUNCE.
- DEBOUNCE:
  - key_s == 0: go to IDLE, no output.
  - key_s != cand: cand ← key_s, cnt ← 1.
  - Otherwise cnt++.
  - When cnt reaches DEBOUNCE_CYCLES, the press is accepted and the FSM goes to PRESSED.
  - With DEBOUNCE_CYCLES = 1, a press is accepted on the first nonzero sample.
- On acceptance:
  - Exactly one bit set: bcd_digit ← index of that bit, digit_valid pulses, digits ← {digits[4*NUM_DIGITS-5:0], index}. The oldest digit is dropped.
  - Two or more bits set: err_multi pulses; bcd_digit and digits are unchanged.
- PRESSED:
  - Lasts one cycle, during which the output pulse is visible.
  - Then go to RELEASE with cnt ← 0.
- RELEASE:
  - key_s == 0: cnt++.
  - Any nonzero sample: cnt ← 0.
  - When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - A held key therefore never repeats; a new press needs a full debounced release first.

Boundary rules:
- digit_valid and err_multi are never high in the same cycle.
- Each accepted press produces exactly one pulse.
- Bounce to zero during DEBOUNCE aborts silently.
- Reset mid-operation:
  - Asynchronously clears state to IDLE, cnt, cand, and key_s.
  - Clears every output: bcd_digit = 0, digit_valid = 0, err_multi = 0, digits = 0, busy = 0.

## Timing

- Reset value of every output is 0.
- Latency: with key held steady from edge 1, key_s is loaded at edge 1 and samples are counted at edges 2..DEBOUNCE_CYCLES+1. digit_valid / err_multi are high from edge DEBOUNCE_CYCLES+1 to edge DEBOUNCE_CYCLES+2. bcd_digit and digits update at edge DEBOUNCE_CYCLES+1.
- busy:
  - Rises at edge 2, when the FSM leaves IDLE.
  - Falls at the edge that completes the DEBOUNCE_CYCLES-th zero sample in RELEASE.
- cnt width is $clog2(DEBOUNCE_CYCLES+1) and saturates at DEBOUNCE_CYCLES.
- There is no ready/backpressure: the consumer must take bcd_digit on the digit_valid cycle.

## Configuration

- KEYPAD_BCD_SYNC_EN defined:
  - key passes through a two-flop synchronizer before key_s, for asynchronous physical switches.
  - All latencies in Timing increase by 1 edge: pulse at edge DEBOUNCE_CYCLES+2.
- Undefined: single input register as described above. Use this for synchronous stimulus.

## Test plan

- Reset, then hold key = 10'b0010000000 from edge 1 (DEBOUNCE_CYCLES = 4, NUM_DIGITS = 2) -> digit_valid high for exactly one cycle after edge 5; bcd_digit = 4'd7; digits = 8'h07; no further pulse while the key is held.
- Press 3, release for ≥ 4 cycles, then press 9 -> two pulses; digits = 8'h39. Press 5 afterwards -> digits = 8'h95.
- Hold key = 10'b0000100001 (keys 0 and 5) -> err_multi single pulse; digit_valid stays 0; digits unchanged.
- Bounce: key[2] high 2 cycles, low 1 cycle, high 2 cycles, low -> no pulse, FSM back to IDLE. Then hold key[2] for 4 or more cycles -> one pulse, bcd_digit = 4'd2.
- Release bounce: after accepting 4, key toggles 0/4 every 2 cycles, then is held at 4 -> no second pulse; busy stays 1 until 4 consecutive zero samples.
- Assert rst asynchronously mid-DEBOUNCE and mid-RELEASE with digits = 8'h12 -> all outputs 0 immediately, without waiting for a clock edge; after deassert, the next clean press of 6 gives digits = 8'h06.
